pc_fetch_unit: RTL

- Holds the architectural program counter and sequences instruction fetch for the single-cycle RISC-V core.
- Drives the current PC into the PC+4 adder and consumes the adder's result and the branch-target result to form the next PC.
- Runs a small fetch handshake with instruction memory.
- Gates commit through a ready/valid-style state machine.
- Flags misaligned control-flow targets as traps.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_fetch_unit_if.sv | 26 ++
 rtl/pc_next_mux.sv | 30 +++
 rtl/pc_fetch_unit.sv | 98 +++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the PC / fetch sequencing slice.
// Contents: sequencer state enum, pc_sel encodings, default parameter values.
package pc_pkg;

  localparam int unsigned XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // PC_RSVD is decoded exactly like PC_SEQ.
  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JALR = 2'b10,
    PC_RSVD = 2'b11
  } pc_sel_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake.
//   imem_req   : fetch request (fetch unit -> memory)
//   imem_addr  : fetch address (fetch unit -> memory)
//   imem_ready : instruction returned this cycle (memory -> fetch unit)
// master = fetch unit, slave = instruction memory.
interface pc_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready
  );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC selection, purely combinational.
// Inputs : pc_sel, branch_taken, pc_plus4, branch_target, jalr_target
// Outputs: next_pc    - selected candidate (JALR target has bit 0 cleared)
//          misaligned - next_pc is not 4-byte aligned (no C extension)
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]      pc_sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      PC_BR:   if (branch_taken) next_pc = branch_target;
      PC_JALR: next_pc = {jalr_target[XLEN-1:1], 1'b0};
      default: next_pc = pc_plus4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for the single-cycle core.
// Ports:
//   clk, resetn      : clock, asynchronous active-low reset
//   pc               : current PC (to PC+4 adder and branch adder)
//   pc_plus4         : PC+4 adder result
//   branch_target    : branch/JAL adder result
//   jalr_target      : rs1+imm from ALU, unmasked
//   pc_sel           : 00 seq, 01 branch/JAL, 10 JALR, 11 treated as seq
//   branch_taken     : qualifies pc_sel=01
//   commit/stall/halt: instruction completion control (stall wins over commit)
//   imem             : fetch handshake (master side)
//   inst_valid       : fetched instruction valid for decode
//   misalign_trap    : one-cycle pulse after a misaligned-target trap
//   mepc             : PC of the instruction that caused the last trap
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [XLEN-1:0]   jalr_target,
  input  logic [1:0]        pc_sel,
  input  logic              branch_taken,
  input  logic              commit,
  input  logic              stall,
  input  logic              halt,
  pc_fetch_unit_if.master   imem,
  output logic              inst_valid,
  output logic              misalign_trap,
  output logic [XLEN-1:0]   mepc
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] mepc_q;
  logic            trap_q;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  pc_next_mux #(
    .XLEN (XLEN)
  ) u_next_mux (
    .pc_sel        (pc_sel),
    .branch_taken  (branch_taken),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .next_pc       (next_pc),
    .misaligned    (next_misaligned)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= BOOT;
      pc_q   <= RESET_VECTOR;
      mepc_q <= '0;
      trap_q <= 1'b0;
    end else begin
      trap_q <= 1'b0;
      case (state)
        BOOT:  state <= FETCH;
        FETCH: if (imem.imem_ready) state <= EXEC;
        EXEC: begin
          if (commit && !stall) begin
            // halt is checked first so a halting instruction never traps
            if (halt) begin
              state <= HALT;
            end else if (next_misaligned) begin
              mepc_q <= pc_q;
              pc_q   <= TRAP_VECTOR;
              trap_q <= 1'b1;
              state  <= FETCH;
            end else begin
              pc_q  <= next_pc;
              state <= FETCH;
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

  assign pc             = pc_q;
  assign mepc           = mepc_q;
  assign misalign_trap  = trap_q;
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc_q;
  assign inst_valid     = (state == EXEC);

endmodule
